// File: rtl/gate_bist_ctrl.sv
// Self-test controller for the 2-input logic-gate block: sweeps {a,b} through all
// four vectors, checks the seven gate results against a fixed truth table and reports pass/fail.
module gate_bist_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int NUM_PASSES    = 1,
   parameter int ERR_CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 a,
   output logic                 b,
   input  logic [6:0]           gate_res,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [1:0]           fail_vec,
   output logic [6:0]           fail_mask
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t          state;
   logic [1:0]      vec;
   logic [1:0]      vec_nxt;
   logic [SW-1:0]   settle_cnt;
   logic [PW-1:0]   pass_idx;
   logic [6:0]      expected;
   logic [6:0]      diff;

   // Truth table, bit order {and,or,not(a),nand,nor,xor,xnor}.
   always_comb begin
      expected = 7'h1D;
      case (vec)
         2'b00: expected = 7'h1D;
         2'b01: expected = 7'h3A;
         2'b10: expected = 7'h2A;
         2'b11: expected = 7'h61;
         default: expected = 7'h1D;
      endcase
      diff    = expected ^ gate_res;
      vec_nxt = vec + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         pass_idx   <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
         fail_mask  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  vec        <= '0;
                  pass_idx   <= '0;
                  settle_cnt <= '0;
                  a          <= 1'b0;
                  b          <= 1'b0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_vec   <= '0;
                  fail_mask  <= '0;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST)
                  state <= SAMPLE;
               else
                  settle_cnt <= settle_cnt + 1'b1;
            end
            SAMPLE: begin
               // err_count never returns to zero within a run, so zero marks the first mismatch.
               if (diff != '0) begin
                  if (err_count != '1)
                     err_count <= err_count + 1'b1;
                  if (err_count == '0) begin
                     fail_vec  <= vec;
                     fail_mask <= diff;
                  end
               end
               if (vec != 2'b11 || pass_idx != PASS_LAST) begin
                  if (vec == 2'b11)
                     pass_idx <= pass_idx + 1'b1;
                  vec        <= vec_nxt;
                  a          <= vec_nxt[1];
                  b          <= vec_nxt[0];
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end else begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               pass  <= (err_count == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three parameterisations driven against a faultable gate model,
// checked against directed vectors and a sweep-level reference model.
module tb_gate_bist_ctrl;

   localparam int S_TAB[3]   = '{1, 1, 3};
   localparam int P_TAB[3]   = '{1, 2, 1};
   localparam int MAX_TAB[3] = '{15, 3, 15};

   logic clk = 1'b0;
   logic rst;
   logic start;
   int   sel;
   logic [27:0] cor;

   logic       st0, st1, st2;
   logic       a0, a1, a2, b0, b1, b2;
   logic [6:0] gr0, gr1, gr2;
   logic       bz0, bz1, bz2, dn0, dn1, dn2, ps0, ps1, ps2;
   logic [3:0] ec0, ec2;
   logic [1:0] ec1;
   logic [1:0] fv0, fv1, fv2;
   logic [6:0] fm0, fm1, fm2;

   logic       a_s, b_s, busy_s, done_s, pass_s;
   logic [3:0] ec_s;
   logic [1:0] fv_s;
   logic [6:0] fm_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign st0 = start && (sel == 0);
   assign st1 = start && (sel == 1);
   assign st2 = start && (sel == 2);

   function automatic logic [6:0] gate(input logic ai, input logic bi, input logic [27:0] c);
      logic [6:0]  good;
      logic [27:0] t;
      good = {ai & bi, ai | bi, ~ai, ~(ai & bi), ~(ai | bi), ai ^ bi, ~(ai ^ bi)};
      t = c >> (7 * int'({ai, bi}));
      return good ^ t[6:0];
   endfunction

   always_comb begin
      gr0 = gate(a0, b0, cor);
      gr1 = gate(a1, b1, cor);
      gr2 = gate(a2, b2, cor);
   end

   gate_bist_ctrl #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .gate_res(gr0),
      .busy(bz0), .done(dn0), .pass(ps0), .err_count(ec0), .fail_vec(fv0), .fail_mask(fm0));
   gate_bist_ctrl #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .gate_res(gr1),
      .busy(bz1), .done(dn1), .pass(ps1), .err_count(ec1), .fail_vec(fv1), .fail_mask(fm1));
   gate_bist_ctrl #(.SETTLE_CYCLES(3), .NUM_PASSES(1), .ERR_CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .gate_res(gr2),
      .busy(bz2), .done(dn2), .pass(ps2), .err_count(ec2), .fail_vec(fv2), .fail_mask(fm2));

   always_comb begin
      case (sel)
         1: begin
            a_s = a1; b_s = b1; busy_s = bz1; done_s = dn1; pass_s = ps1;
            ec_s = {2'b00, ec1}; fv_s = fv1; fm_s = fm1;
         end
         2: begin
            a_s = a2; b_s = b2; busy_s = bz2; done_s = dn2; pass_s = ps2;
            ec_s = ec2; fv_s = fv2; fm_s = fm2;
         end
         default: begin
            a_s = a0; b_s = b0; busy_s = bz0; done_s = dn0; pass_s = ps0;
            ec_s = ec0; fv_s = fv0; fm_s = fm0;
         end
      endcase
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         fails++;
         $display("FAIL %s (dut%0d): got %0d expected %0d", nm, sel, act, exp_v);
      end
   endtask

   // Sweep-level reference: walk every sample of every pass and tally mismatches.
   task automatic model(input logic [27:0] c, input int np, input int mx,
                        output int e, output int fv, output int fm, output bit ps);
      bit          first;
      logic [27:0] t;
      e = 0; fv = 0; fm = 0; first = 1'b1;
      for (int p = 0; p < np; p++)
         for (int v = 0; v < 4; v++) begin
            t = c >> (7 * v);
            if (t[6:0] != 7'h00) begin
               if (first) begin
                  fv = v; fm = int'(t[6:0]); first = 1'b0;
               end
               if (e < mx) e++;
            end
         end
      ps = (e == 0);
   endtask

   task automatic do_run(input logic [27:0] c, input int poke, input bit hold,
                         input int e_err, input int e_fv, input int e_fm, input bit e_pass);
      int s, l;
      s = S_TAB[sel];
      l = 4 * (s + 1) * P_TAB[sel] + 1;
      cor = c;
      start = 1'b1;
      @(posedge clk); #1;
      start = hold;
      for (int k = 1; k <= l; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            chk("cleared_err", int'(ec_s), 0);
            chk("cleared_pass", int'(pass_s), 0);
         end
         if (k <= l - 2) begin
            chk($sformatf("busy_k%0d", k), int'(busy_s), 1);
            chk($sformatf("done_early_k%0d", k), int'(done_s), 0);
            chk($sformatf("ab_k%0d", k), int'({a_s, b_s}), (k / (s + 1)) % 4);
         end else if (k == l - 1) begin
            chk("busy_in_done", int'(busy_s), 0);
            chk("done_early_last", int'(done_s), 0);
         end else begin
            chk("done_pulse", int'(done_s), 1);
            chk("busy_at_done", int'(busy_s), 0);
            chk("err_count", int'(ec_s), e_err);
            chk("fail_vec", int'(fv_s), e_fv);
            chk("fail_mask", int'(fm_s), e_fm);
            chk("pass", int'(pass_s), int'(e_pass));
         end
         start = hold || (k == poke);
      end
   endtask

   task automatic idle_gap(input int n, input int e_err, input bit e_pass);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("done_once", int'(done_s), 0);
         chk("idle_busy", int'(busy_s), 0);
         chk("err_held", int'(ec_s), e_err);
         chk("pass_held", int'(pass_s), int'(e_pass));
      end
   endtask

   typedef struct {
      int          sel;
      logic [27:0] cor;
      int          poke;
      bit          hold;
      int          e_err;
      int          e_fv;
      int          e_fm;
      bit          e_pass;
   } tv_t;

   tv_t tbl[7];

   initial begin
      int e, fv, fm, poke, l;
      bit ps;
      logic [27:0] c;

      tbl[0] = '{0, 28'h0,                                  0, 1'b0, 0, 0, 7'h00, 1'b1};
      tbl[1] = '{0, 28'h0008100,                            0, 1'b0, 2, 1, 7'h02, 1'b0};
      tbl[2] = '{1, {7'h61, 7'h2A, 7'h3A, 7'h1D},           0, 1'b0, 3, 0, 7'h1D, 1'b0};
      tbl[3] = '{0, 28'h0,                                  0, 1'b1, 0, 0, 7'h00, 1'b1};
      tbl[4] = '{0, 28'h0,                                  0, 1'b0, 0, 0, 7'h00, 1'b1};
      tbl[5] = '{2, 28'h0,                                  5, 1'b0, 0, 0, 7'h00, 1'b1};
      tbl[6] = '{2, {7'h61, 7'h2A, 7'h3A, 7'h1D},           0, 1'b0, 4, 0, 7'h1D, 1'b0};

      rst = 1'b1; start = 1'b0; sel = 0; cor = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         chk("rst_ab", int'({a_s, b_s}), 0);
         chk("rst_busy", int'(busy_s), 0);
         chk("rst_done", int'(done_s), 0);
         chk("rst_pass", int'(pass_s), 0);
         chk("rst_err", int'(ec_s), 0);
         chk("rst_fv", int'(fv_s), 0);
         chk("rst_fm", int'(fm_s), 0);
      end
      sel = 0;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         sel = tbl[i].sel;
         do_run(tbl[i].cor, tbl[i].poke, tbl[i].hold,
                tbl[i].e_err, tbl[i].e_fv, tbl[i].e_fm, tbl[i].e_pass);
         if (!tbl[i].hold) idle_gap(2, tbl[i].e_err, tbl[i].e_pass);
      end

      // Reset while sampling vector 10, after vector 00 already logged a mismatch.
      sel = 0;
      cor = 28'h10;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_ab", int'({a_s, b_s}), 2);
      chk("pre_rst_err", int'(ec_s), 1);
      chk("pre_rst_fm", int'(fm_s), 7'h10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ab", int'({a_s, b_s}), 0);
      chk("abort_busy", int'(busy_s), 0);
      chk("abort_done", int'(done_s), 0);
      chk("abort_pass", int'(pass_s), 0);
      chk("abort_err", int'(ec_s), 0);
      chk("abort_fv", int'(fv_s), 0);
      chk("abort_fm", int'(fm_s), 0);
      idle_gap(12, 0, 1'b0);
      do_run(28'h0, 0, 1'b0, 0, 0, 0, 1'b1);
      idle_gap(1, 0, 1'b1);

      for (int it = 0; it < 40; it++) begin
         sel = int'($urandom_range(0, 2));
         c = '0;
         for (int v = 0; v < 4; v++)
            if ($urandom_range(0, 1) == 1)
               c = c | (28'(7'($urandom_range(1, 127))) << (7 * v));
         model(c, P_TAB[sel], MAX_TAB[sel], e, fv, fm, ps);
         l = 4 * (S_TAB[sel] + 1) * P_TAB[sel] + 1;
         poke = int'($urandom_range(0, l - 1));
         do_run(c, poke, 1'b0, e, fv, fm, ps);
         idle_gap(int'($urandom_range(1, 3)), e, ps);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
